spi_sdo_responder: RTL and testbench

Serial-output responder for the chip-select/serial-data link: the transmitting end of the link that `bitshifter` receives. It accepts parallel words from local logic through a one-entry valid/ready buffer and shifts them out MSB-first on `sdo` while the master holds `cs` high and toggles `sclk`. It runs entirely on the system clock. `cs` and `sclk` are oversampled through synchronizers, so no second clock domain exists.

---
 rtl/spi_sdo_responder.sv | 118 +++++++++++
 tb/tb_spi_sdo_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_sdo_responder.sv
// spi_sdo_responder: buffered MSB-first serial transmitter driven by an oversampled cs/sclk master
module spi_sdo_responder #(
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] IDLE_WORD = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic              cs,
   input  logic              sclk,
   output logic              sdo,
   output logic              sdo_en,
   output logic              word_done,
   output logic              underrun,
   output logic              aborted
);
   localparam int CW = $clog2(DATA_W + 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state_q, state_d;
   logic [2:0]        cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
   logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
   logic              hold_full_q, hold_full_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              sdo_q, sdo_d, sdo_en_q, sdo_en_d;
   logic              word_done_q, word_done_d, underrun_q, underrun_d, aborted_q, aborted_d;
   logic              cs_rise, cs_fall, sclk_rise, sclk_fall, cnt_full, load;

   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cnt_full  = bit_cnt_q == CW'(DATA_W);

   always_comb begin
      cs_sync_d   = {cs_sync_q[1:0], cs};
      sclk_sync_d = {sclk_sync_q[1:0], sclk};
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      word_done_d = 1'b0;
      underrun_d  = 1'b0;
      aborted_d   = 1'b0;
      load        = 1'b0;
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
      if (state_q == IDLE) begin
         if (cs_rise) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            load      = 1'b1;
         end
      end else if (cs_fall) begin
         state_d   = IDLE;
         aborted_d = bit_cnt_q != '0;
      end else if (sclk_rise) begin
         bit_cnt_d = cnt_full ? bit_cnt_q : bit_cnt_q + 1'b1;
      end else if (sclk_fall) begin
         if (cnt_full) begin
            word_done_d = 1'b1;
            bit_cnt_d   = '0;
            load        = 1'b1;
         end else begin
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
         end
      end
      // a load from an empty buffer may coincide with an accept, which must keep hold_full set
      if (load) begin
         shift_d    = hold_full_q ? hold_q : IDLE_WORD;
         underrun_d = !hold_full_q;
         if (hold_full_q) hold_full_d = 1'b0;
      end
      sdo_en_d = state_d == SHIFT;
      sdo_d    = sdo_en_d & shift_d[DATA_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cs_sync_q   <= '0;
         sclk_sync_q <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         sdo_q       <= 1'b0;
         sdo_en_q    <= 1'b0;
         word_done_q <= 1'b0;
         underrun_q  <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         sdo_q       <= sdo_d;
         sdo_en_q    <= sdo_en_d;
         word_done_q <= word_done_d;
         underrun_q  <= underrun_d;
         aborted_q   <= aborted_d;
      end
   end

   assign tx_ready  = !hold_full_q;
   assign sdo       = sdo_q;
   assign sdo_en    = sdo_en_q;
   assign word_done = word_done_q;
   assign underrun  = underrun_q;
   assign aborted   = aborted_q;
endmodule

// File: tb/tb_spi_sdo_responder.sv
// tb_spi_sdo_responder: table-driven frames plus abort/reset/back-to-back sequences, scoreboarded sdo bits
module tb_spi_sdo_responder;
   logic        clk = 1'b0, rst_n, cs, sclk, tx_valid;
   logic [15:0] tx_data;
   logic        tx_ready, sdo, sdo_en, word_done, underrun, aborted;
   int          n_chk = 0, n_fail = 0;
   int          wd_cnt = 0, ur_cnt = 0, ab_cnt = 0;
   int          wd0, ur0, ab0;
   logic        exp_q[$];

   typedef struct {
      logic [15:0] data;
      bit          load;
      int          exp_ur;
   } vec_t;
   vec_t vecs[5];

   spi_sdo_responder dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .cs(cs), .sclk(sclk), .sdo(sdo), .sdo_en(sdo_en), .word_done(word_done),
      .underrun(underrun), .aborted(aborted)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (word_done) wd_cnt++;
      if (underrun) ur_cnt++;
      if (aborted) ab_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   task automatic load(input logic [15:0] w);
      @(negedge clk);
      tx_data  = w;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      check("tx_ready_fall", 32'(tx_ready), 32'd0);
      push_word(w);
   endtask

   task automatic pulse();
      @(negedge clk);
      sclk = 1'b1;
      check("sdo_en_at_sample", 32'(sdo_en), 32'd1);
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL sb_underflow: got sdo %0b with no expected bit queued", sdo);
      end else begin
         check("sdo_bit", 32'(sdo), 32'(exp_q.pop_front()));
      end
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_start();
      @(negedge clk);
      cs = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic frame_end();
      repeat (3) @(negedge clk);
      cs = 1'b0;
      repeat (6) @(negedge clk);
      check("sdo_en_idle", 32'(sdo_en), 32'd0);
      check("sdo_idle", 32'(sdo), 32'd0);
   endtask

   task automatic snap();
      wd0 = wd_cnt;
      ur0 = ur_cnt;
      ab0 = ab_cnt;
   endtask

   initial begin
      vecs[0] = '{16'hA5C3, 1'b1, 1};
      vecs[1] = '{16'h0000, 1'b0, 2};
      vecs[2] = '{16'hFFFF, 1'b1, 1};
      vecs[3] = '{16'h8001, 1'b1, 1};
      vecs[4] = '{16'h5555, 1'b1, 1};
      rst_n = 1'b0; cs = 1'b0; sclk = 1'b0; tx_valid = 1'b0; tx_data = '0;
      repeat (3) @(negedge clk);
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_sdo_en", 32'(sdo_en), 32'd0);
      check("rst_word_done", 32'(word_done), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         snap();
         if (vecs[v].load) load(vecs[v].data);
         else push_word(16'h0000);
         frame_start();
         for (int p = 0; p < 16; p++) pulse();
         frame_end();
         check("vec_word_done", 32'(wd_cnt - wd0), 32'd1);
         check("vec_underrun", 32'(ur_cnt - ur0), 32'(vecs[v].exp_ur));
         check("vec_aborted", 32'(ab_cnt - ab0), 32'd0);
         check("vec_tx_ready", 32'(tx_ready), 32'd1);
         check("vec_sb_drained", 32'(exp_q.size()), 32'd0);
      end

      snap();
      load(16'h1234);
      frame_start();
      pulse();
      check("b2b_ready_after_xfer", 32'(tx_ready), 32'd1);
      load(16'hFFFF);
      for (int p = 0; p < 30; p++) pulse();
      check("b2b_no_underrun", 32'(ur_cnt - ur0), 32'd0);
      check("b2b_mid_word_done", 32'(wd_cnt - wd0), 32'd1);
      pulse();
      frame_end();
      check("b2b_word_done", 32'(wd_cnt - wd0), 32'd2);
      check("b2b_trailing_underrun", 32'(ur_cnt - ur0), 32'd1);
      check("b2b_sb_drained", 32'(exp_q.size()), 32'd0);

      snap();
      load(16'hC3A5);
      frame_start();
      for (int p = 0; p < 5; p++) pulse();
      @(negedge clk);
      cs = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_sdo_en_before", 32'(sdo_en), 32'd1);
      @(negedge clk);
      check("abort_sdo_en_after", 32'(sdo_en), 32'd0);
      repeat (3) @(negedge clk);
      check("abort_pulse", 32'(ab_cnt - ab0), 32'd1);
      check("abort_no_word_done", 32'(wd_cnt - wd0), 32'd0);
      exp_q.delete();
      snap();
      load(16'h3C5A);
      frame_start();
      for (int p = 0; p < 16; p++) pulse();
      frame_end();
      check("post_abort_word_done", 32'(wd_cnt - wd0), 32'd1);
      check("post_abort_aborted", 32'(ab_cnt - ab0), 32'd0);

      load(16'h5A5A);
      frame_start();
      pulse();
      load(16'h0F0F);
      for (int p = 0; p < 6; p++) pulse();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_tx_ready", 32'(tx_ready), 32'd1);
      check("midrst_sdo", 32'(sdo), 32'd0);
      check("midrst_sdo_en", 32'(sdo_en), 32'd0);
      check("midrst_pulses", 32'({word_done, underrun, aborted}), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      snap();
      repeat (5) @(negedge clk);
      check("restart_underrun", 32'(ur_cnt - ur0), 32'd1);
      check("restart_sdo_en", 32'(sdo_en), 32'd1);
      push_word(16'h0000);
      for (int p = 0; p < 16; p++) pulse();
      frame_end();
      check("restart_word_done", 32'(wd_cnt - wd0), 32'd1);
      check("restart_sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
